// File: rtl/sample_packer.sv
// sample_packer: decimates the probe inputs and packs the enabled channels of each sample
// into a dense bitstream. The bits go in LSB-first, and every completed 16-bit word is
// pushed to the sample FIFO with a one-cycle write strobe.
//
// Ports:
//   i_clk               fast sample clock, rising edge
//   i_rst               synchronous active-high reset
//   i_acq_enable        acquisition run level (already in i_clk domain)
//   i_clock_divisor     decimation divisor, latched on IDLE->RUN
//   i_channel_enable    per-channel enable mask, latched on IDLE->RUN
//   i_probe             raw probe pins
//   o_sample_data       packed word (FIFO din)
//   o_sample_data_avail one-cycle write strobe (FIFO wr_en)
//   o_active            high in RUN, DRAIN and FLUSH
module sample_packer #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_acq_enable,
    input  logic [DIV_WIDTH-1:0] i_clock_divisor,
    input  logic [15:0]          i_channel_enable,
    input  logic [15:0]          i_probe,
    output logic [15:0]          o_sample_data,
    output logic                 o_sample_data_avail,
    output logic                 o_active
);

    localparam logic [DIV_WIDTH-1:0] DivOne = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFlush} state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [15:0]          r_en;
    logic [4:0]           r_n;
    logic                 r_drain_cnt;
    logic [15:0]          r_s1;
    logic                 r_s1_valid;
    logic [15:0]          r_s2;
    logic                 r_s2_valid;
    logic [30:0]          r_acc;
    logic [4:0]           r_fill;
    logic [15:0]          r_data;
    logic                 r_avail;
    logic                 r_active;

    logic                 w_strobe;
    logic [4:0]           w_popcnt;
    logic [15:0]          w_compact;
    logic [3:0]           w_idx;
    logic [30:0]          w_new;
    logic [4:0]           w_f;

    assign w_strobe = (r_state == StRun) && i_acq_enable && (r_cnt == '0);

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < 16; i++) begin
            w_popcnt = w_popcnt + {4'd0, i_channel_enable[i]};
        end
    end

    // Enabled channels land in ascending order in the low bits. The 4-bit index wraps only
    // after the 16th write, so no write ever uses the wrapped value.
    always_comb begin
        w_compact = '0;
        w_idx     = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_en[i]) begin
                w_compact[w_idx] = r_s1[i];
                w_idx            = w_idx + 4'd1;
            end
        end
    end

    // fill <= 15 and N <= 16, so f <= 31 fits in 5 bits and new fits in 31 bits.
    assign w_new = r_acc | ({15'd0, r_s2} << r_fill);
    assign w_f   = r_fill + r_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_div       <= '0;
            r_cnt       <= '0;
            r_en        <= '0;
            r_n         <= '0;
            r_drain_cnt <= 1'b0;
            r_s1        <= '0;
            r_s1_valid  <= 1'b0;
            r_s2        <= '0;
            r_s2_valid  <= 1'b0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_data      <= '0;
            r_avail     <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_avail <= 1'b0;

            // Stages 1 and 2: capture the sample, then compact it.
            r_s1_valid <= w_strobe;
            if (w_strobe) begin
                r_s1 <= i_probe;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_compact;
            end

            // Stage 3: accumulate. A sample completes at most one word.
            if (r_s2_valid) begin
                if (w_f >= 5'd16) begin
                    r_data  <= w_new[15:0];
                    r_avail <= 1'b1;
                    r_acc   <= {16'd0, w_new[30:16]};
                    r_fill  <= w_f - 5'd16;
                end else begin
                    r_acc  <= w_new;
                    r_fill <= w_f;
                end
            end

            case (r_state)
                StIdle: begin
                    if (i_acq_enable) begin
                        r_div    <= i_clock_divisor;
                        r_en     <= i_channel_enable;
                        r_n      <= w_popcnt;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_fill   <= '0;
                        r_state  <= StRun;
                        r_active <= 1'b1;
                    end
                end
                StRun: begin
                    r_cnt <= (r_cnt == r_div) ? '0 : r_cnt + DivOne;
                    if (!i_acq_enable) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= 1'b0;
                    end
                end
                StDrain: begin
                    // Two cycles let the last stage-1/2 samples reach the accumulator.
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state <= StFlush;
                    end
                end
                StFlush: begin
                    if (r_fill != 5'd0) begin
                        r_data  <= r_acc[15:0];
                        r_avail <= 1'b1;
                        r_fill  <= '0;
                        r_acc   <= '0;
                    end
                    r_state  <= StIdle;
                    r_active <= 1'b0;
                end
                default: begin
                    r_state  <= StIdle;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_sample_data       = r_data;
    assign o_sample_data_avail = r_avail;
    assign o_active            = r_active;

endmodule

// File: tb/tb_sample_packer.sv
// Testbench for sample_packer. It applies a table of acquisition runs, with the config
// inputs scrambled after each start, and then runs a mid-operation reset sequence.
module tb_sample_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        acq;
    logic [7:0]  div;
    logic [15:0] en;
    logic [15:0] probe;
    logic [15:0] data;
    logic        avail;
    logic        active;

    always #5 clk = ~clk;

    sample_packer #(.DIV_WIDTH(8)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_acq_enable       (acq),
        .i_clock_divisor    (div),
        .i_channel_enable   (en),
        .i_probe            (probe),
        .o_sample_data      (data),
        .o_sample_data_avail(avail),
        .o_active           (active)
    );

    typedef struct packed {
        logic [15:0]       en;
        logic [7:0]        div;
        logic [7:0]        run;       // RUN cycles with acq_enable high
        logic [15:0]       probe0;
        logic [15:0]       step;      // probe added per RUN cycle
        logic [7:0]        nwords;
        logic [9:0][15:0]  words;
        logic [7:0]        first_cyc; // offset of first avail from RUN cycle 0
        logic [7:0]        last_cyc;
    } rec_t;

    int          cyc = 0;
    logic [15:0] wq[$];
    int          wt[$];
    int          n_tests = 0;
    int          n_fail = 0;
    rec_t        vec[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avail === 1'b1) begin
            wq.push_back(data);
            wt.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_rec(input rec_t r, input int idx);
        int t0;
        int i;
        wq.delete();
        wt.delete();
        en    = r.en;
        div   = r.div;
        probe = r.probe0;
        acq   = 1'b1;
        @(posedge clk) #1;
        t0  = cyc;
        // Later config changes must be ignored until the next start.
        en  = r.en ^ 16'hFFF0;
        div = r.div + 8'd5;
        for (int k = 0; k < int'(r.run); k++) begin
            probe = r.probe0 + 16'(k) * r.step;
            if (k == 0) begin
                @(negedge clk);
                chk($sformatf("rec%0d active_run", idx), {31'd0, active}, 32'd1);
            end
            @(posedge clk) #1;
        end
        acq = 1'b0;
        i = 0;
        while (active === 1'b1 && i < 30) begin
            @(posedge clk) #1;
            i++;
        end
        chk($sformatf("rec%0d active_end", idx), {31'd0, active}, 32'd0);
        repeat (3) @(posedge clk) #1;
        chk($sformatf("rec%0d nwords", idx), wq.size(), {24'd0, r.nwords});
        for (int w = 0; w < wq.size() && w < int'(r.nwords); w++) begin
            chk($sformatf("rec%0d word%0d", idx, w), {16'd0, wq[w]}, {16'd0, r.words[w]});
        end
        if (wq.size() > 0) begin
            chk($sformatf("rec%0d first_lat", idx), wt[0] - t0, {24'd0, r.first_cyc});
            chk($sformatf("rec%0d last_lat", idx), wt[wq.size()-1] - t0,
                {24'd0, r.last_cyc});
        end
    endtask

    initial begin
        // Table: en, div, run, probe0, step, nwords, words, first, last
        vec[0] = '{16'h00FF, 8'd0, 8'd2, 16'h12AB, 16'h2222, 8'd1, '0, 8'd4, 8'd4};
        vec[0].words[0] = 16'hCDAB;
        vec[1] = '{16'h0007, 8'd0, 8'd6, 16'h0005, 16'h0000, 8'd2, '0, 8'd8, 8'd10};
        vec[1].words[0] = 16'hDB6D;
        vec[1].words[1] = 16'h0002;
        vec[2] = '{16'hFFFF, 8'd0, 8'd4, 16'h0001, 16'h0001, 8'd4, '0, 8'd3, 8'd6};
        for (int w = 0; w < 4; w++) vec[2].words[w] = 16'(w + 1);
        vec[3] = '{16'hFFFF, 8'd3, 8'd40, 16'h0001, 16'h0001, 8'd10, '0, 8'd3, 8'd39};
        for (int w = 0; w < 10; w++) vec[3].words[w] = 16'(4 * w + 1);
        vec[4] = '{16'hF00F, 8'd0, 8'd2, 16'h1234, 16'h1111, 8'd1, '0, 8'd4, 8'd4};
        vec[4].words[0] = 16'h2514;
        vec[5] = '{16'h8001, 8'd1, 8'd8, 16'h8000, 16'h0000, 8'd1, '0, 8'd12, 8'd12};
        vec[5].words[0] = 16'h00AA;

        rst   = 1'b1;
        acq   = 1'b0;
        div   = '0;
        en    = '0;
        probe = '0;
        repeat (3) @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset data", {16'd0, data}, 32'd0);
        chk("reset avail", {31'd0, avail}, 32'd0);
        chk("reset active", {31'd0, active}, 32'd0);
        @(posedge clk) #1;

        for (int r = 0; r < 6; r++) run_rec(vec[r], r);

        // A zero mask with a long run must never strobe.
        run_rec('{16'h0000, 8'd0, 8'd100, 16'hFFFF, 16'h0000, 8'd0, '0, 8'd0, 8'd0}, 6);

        // Reset while fill=8: no flush word, outputs cleared on the next cycle.
        en    = 16'h00FF;
        div   = 8'd0;
        probe = 16'h00AB;
        acq   = 1'b1;
        @(posedge clk) #1;          // RUN cycle 0, sample taken at its end
        @(posedge clk) #1;          // RUN cycle 1
        acq = 1'b0;
        wq.delete();
        wt.delete();
        @(posedge clk) #1;          // DRAIN 1: accumulator gets fill=8 at its end
        @(posedge clk) #1;          // DRAIN 2
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid data", {16'd0, data}, 32'd0);
        chk("rst_mid avail", {31'd0, avail}, 32'd0);
        chk("rst_mid active", {31'd0, active}, 32'd0);
        repeat (6) @(posedge clk) #1;
        chk("rst_mid no_flush", wq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
